// File: rtl/imem_program_loader.sv
// Writer side of the SPU_Lite instruction memory: packs a big-endian byte stream
// into 32-bit words, zero-fills the remainder and holds the core until complete.
module imem_program_loader #(
   parameter int DEPTH_BYTES = 1024,
   parameter int LEN_W       = 11,
   parameter int WADDR_W     = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [LEN_W-1:0]   len,
   input  logic               in_valid,
   input  logic [0:7]         in_data,
   output logic               in_ready,
   output logic               wr_en,
   output logic [WADDR_W-1:0] wr_addr,
   output logic [0:31]        wr_data,
   output logic               busy,
   output logic               done,
   output logic               core_hold,
   output logic               err_len,
   output logic [1:0]         dbg_state_o
);

   localparam int DEPTH_WORDS = DEPTH_BYTES / 4;
   localparam logic [WADDR_W:0] LAST_WORD = (WADDR_W+1)'(DEPTH_WORDS - 1);
   localparam logic [WADDR_W:0] ALL_WORDS = (WADDR_W+1)'(DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_FILL = 2'd2, S_DONE = 2'd3} state_t;

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [WADDR_W:0]   words_q, words_d;
   logic [0:31]        word_q, word_d;
   logic [0:31]        word_nxt;
   logic               wr_en_q, wr_en_d;
   logic [WADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [0:31]        wr_data_q, wr_data_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               core_hold_q, core_hold_d;
   logic               err_len_q, err_len_d;

   logic len_too_big;
   logic byte_xfer;
   logic last_byte;

   // Handshake: a byte moves on a rising edge when in_valid && in_ready; in_ready
   // is decoded from state and counters only, so it never waits on in_valid.
   assign in_ready    = (state_q == S_LOAD) && (byte_cnt_q != len_q);
   assign byte_xfer   = in_ready && in_valid;
   assign last_byte   = (byte_cnt_q + LEN_W'(1)) == len_q;
   assign len_too_big = len > LEN_W'(DEPTH_BYTES);

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start && !len_too_big) state_d = (len == '0) ? S_FILL : S_LOAD;
         S_LOAD: if (byte_xfer && last_byte) state_d = S_FILL;
         S_FILL: if (words_q == ALL_WORDS || words_q == LAST_WORD) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      len_d       = len_q;
      byte_cnt_d  = byte_cnt_q;
      words_d     = words_q;
      word_d      = word_q;
      word_nxt    = word_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      err_len_d   = 1'b0;
      busy_d      = (state_d == S_LOAD) || (state_d == S_FILL);
      done_d      = (state_d == S_DONE);
      core_hold_d = core_hold_q;
      if (state_d == S_DONE)     core_hold_d = 1'b0;
      else if (busy_d)           core_hold_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len_too_big) begin
                  err_len_d = 1'b1;
               end else begin
                  len_d      = len;
                  byte_cnt_d = '0;
                  words_d    = '0;
                  word_d     = '0;
                  wr_addr_d  = '0;
               end
            end
         end
         S_LOAD: begin
            if (byte_xfer) begin
               byte_cnt_d = byte_cnt_q + LEN_W'(1);
               case (byte_cnt_q[1:0])
                  2'd0:    word_nxt[0:7]   = in_data;
                  2'd1:    word_nxt[8:15]  = in_data;
                  2'd2:    word_nxt[16:23] = in_data;
                  default: word_nxt[24:31] = in_data;
               endcase
               // Unused lanes of a trailing partial word are already zero because
               // the assembly register is cleared after every write.
               if (byte_cnt_q[1:0] == 2'd3 || last_byte) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = words_q[WADDR_W-1:0];
                  wr_data_d = word_nxt;
                  words_d   = words_q + (WADDR_W+1)'(1);
                  word_d    = '0;
               end else begin
                  word_d = word_nxt;
               end
            end
         end
         S_FILL: begin
            if (words_q != ALL_WORDS) begin
               wr_en_d   = 1'b1;
               wr_addr_d = words_q[WADDR_W-1:0];
               wr_data_d = '0;
               words_d   = words_q + (WADDR_W+1)'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         len_q       <= '0;
         byte_cnt_q  <= '0;
         words_q     <= '0;
         word_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         core_hold_q <= 1'b1;
         err_len_q   <= 1'b0;
      end else begin
         len_q       <= len_d;
         byte_cnt_q  <= byte_cnt_d;
         words_q     <= words_d;
         word_q      <= word_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         core_hold_q <= core_hold_d;
         err_len_q   <= err_len_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign core_hold   = core_hold_q;
   assign err_len     = err_len_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: table of load scenarios, scoreboard of expected
// IMem writes, shadow IMem image compared word by word after every load.
module tb_imem_program_loader;
   localparam int DEPTH_BYTES = 1024;
   localparam int LEN_W       = 11;
   localparam int WADDR_W     = 8;
   localparam int NWORDS      = DEPTH_BYTES / 4;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic [LEN_W-1:0]   len = '0;
   logic               in_valid = 1'b0;
   logic [0:7]         in_data = '0;
   logic               in_ready;
   logic               wr_en;
   logic [WADDR_W-1:0] wr_addr;
   logic [0:31]        wr_data;
   logic               busy;
   logic               done;
   logic               core_hold;
   logic               err_len;
   logic [1:0]         dbg_state;

   imem_program_loader #(.DEPTH_BYTES(DEPTH_BYTES), .LEN_W(LEN_W), .WADDR_W(WADDR_W)) dut (
      .clk(clk), .reset(reset), .start(start), .len(len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .core_hold(core_hold), .err_len(err_len),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [WADDR_W+32-1:0] exp_q[$];
   logic [31:0] imem_sh[NWORDS];
   logic [31:0] exp_img[NWORDS];
   logic [7:0]  prog[DEPTH_BYTES];
   int wr_cnt = 0;
   int done_cnt = 0;
   bit exp_core_hold = 1'b1;

   typedef struct {
      int len;
      bit rand_valid;
      bit inject_start;
      int abort_at;
      bit exp_err;
   } vec_t;
   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard / monitor on the falling edge
   always @(negedge clk) begin
      logic [WADDR_W+32-1:0] e;
      if (wr_en === 1'b1) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0d data %h, expected no write", wr_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(wr_addr), 64'(e[WADDR_W+31:32]));
            chk("wr_data", 64'(wr_data), 64'(e[31:0]));
         end
         imem_sh[wr_addr] = wr_data;
      end
      if (done === 1'b1) begin
         done_cnt++;
         chk("core_hold_at_done", 64'(core_hold), 64'd0);
         chk("busy_at_done", 64'(busy), 64'd0);
      end
   end

   task automatic run_vec(input vec_t v);
      int n, idx, cyc, wr0, done0;
      bit xfer, rdy_seen;
      logic [31:0] word;
      n = v.len;
      if (!v.exp_err) begin
         for (int w = 0; w < NWORDS; w++) begin
            word = '0;
            for (int b = 0; b < 4; b++)
               if (w * 4 + b < n) word[31 - 8*b -: 8] = prog[w * 4 + b];
            exp_img[w] = word;
            exp_q.push_back({WADDR_W'(w), word});
         end
      end
      wr0 = wr_cnt;
      done0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1;
      len = LEN_W'(n);
      @(posedge clk); #1;
      start = 1'b0;
      if (v.exp_err) begin
         chk("err_len_pulse", 64'(err_len), 64'd1);
         chk("err_busy", 64'(busy), 64'd0);
         chk("err_in_ready", 64'(in_ready), 64'd0);
         @(posedge clk); #1;
         chk("err_len_one_cycle", 64'(err_len), 64'd0);
         chk("err_state_idle", 64'(dbg_state), 64'd0);
         chk("err_core_hold", 64'(core_hold), 64'(exp_core_hold));
         repeat (3) @(posedge clk);
         #1;
         chk("err_no_writes", 64'(wr_cnt - wr0), 64'd0);
         return;
      end
      chk("start_busy", 64'(busy), 64'd1);
      chk("start_core_hold", 64'(core_hold), 64'd1);
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 5000) begin
         in_valid = v.rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = prog[idx];
         if (v.inject_start && idx == 5) begin
            start = 1'b1;
            len = LEN_W'(4);
         end
         xfer = in_valid && in_ready;
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
         if (xfer) idx++;
         if (v.abort_at >= 0 && idx == v.abort_at) begin
            in_valid = 1'b0;
            reset = 1'b1;
            @(posedge clk); #1;
            chk("abort_core_hold", 64'(core_hold), 64'd1);
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_wr_en", 64'(wr_en), 64'd0);
            chk("abort_in_ready", 64'(in_ready), 64'd0);
            chk("abort_state_idle", 64'(dbg_state), 64'd0);
            chk("abort_words_written", 64'(wr_cnt - wr0), 64'(v.abort_at / 4));
            reset = 1'b0;
            exp_q.delete();
            exp_core_hold = 1'b1;
            return;
         end
      end
      chk("stream_timeout", 64'(idx), 64'(n));
      // Keep in_valid high: no byte beyond len may be taken
      in_valid = 1'b1;
      in_data  = 8'hEE;
      chk("in_ready_after_last", 64'(in_ready), 64'd0);
      rdy_seen = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 3000) begin
         @(posedge clk); #1;
         if (in_ready === 1'b1) rdy_seen = 1'b1;
         cyc++;
      end
      chk("in_ready_held_low", 64'(rdy_seen), 64'd0);
      chk("done_seen", 64'(done), 64'd1);
      chk("done_core_hold", 64'(core_hold), 64'd0);
      exp_core_hold = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("back_to_idle", 64'(dbg_state), 64'd0);
      chk("idle_core_hold", 64'(core_hold), 64'd0);
      chk("write_count", 64'(wr_cnt - wr0), 64'(NWORDS));
      chk("done_pulses", 64'(done_cnt - done0), 64'd1);
      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      for (int w = 0; w < NWORDS; w++)
         chk($sformatf("imem_word_%0d", w), 64'(imem_sh[w]), 64'(exp_img[w]));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < DEPTH_BYTES; i++) prog[i] = 8'($urandom_range(0, 255));
      prog[0] = 8'h18; prog[1] = 8'h0A; prog[2] = 8'h0F; prog[3] = 8'h14;
      prog[4] = 8'h31; prog[5] = 8'h00; prog[6] = 8'h05; prog[7] = 8'h32;
      for (int i = 0; i < NWORDS; i++) imem_sh[i] = 32'hDEADBEEF;

      vecs[0] = '{len: 40,   rand_valid: 0, inject_start: 0, abort_at: -1, exp_err: 0};
      vecs[1] = '{len: 6,    rand_valid: 0, inject_start: 0, abort_at: -1, exp_err: 0};
      vecs[2] = '{len: 0,    rand_valid: 0, inject_start: 0, abort_at: -1, exp_err: 0};
      vecs[3] = '{len: 40,   rand_valid: 1, inject_start: 0, abort_at: -1, exp_err: 0};
      vecs[4] = '{len: 1025, rand_valid: 0, inject_start: 0, abort_at: -1, exp_err: 1};
      vecs[5] = '{len: 40,   rand_valid: 0, inject_start: 1, abort_at: -1, exp_err: 0};
      vecs[6] = '{len: 40,   rand_valid: 0, inject_start: 0, abort_at: 17, exp_err: 0};
      vecs[7] = '{len: 1024, rand_valid: 1, inject_start: 0, abort_at: -1, exp_err: 0};
      vecs[8] = '{len: 40,   rand_valid: 1, inject_start: 0, abort_at: -1, exp_err: 0};

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_core_hold", 64'(core_hold), 64'd1);
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("rst_wr_data", 64'(wr_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err_len", 64'(err_len), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i]);
         if (i == 0) begin
            chk("case2_word0", 64'(imem_sh[0]), 64'h180A0F14);
            chk("case2_word1", 64'(imem_sh[1]), 64'h31000532);
         end
         if (i == 1) begin
            chk("len6_word1", 64'(imem_sh[1]), 64'h31000000);
            chk("len6_word2_zero", 64'(imem_sh[2]), 64'd0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
